// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback value, commits it,
// serves two bypassed read ports, and keeps a registered record of retired writes for debug.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [ADDR_W-1:0] wb_dst_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data_out,
    output logic              last_wb_valid,
    output logic [ADDR_W-1:0] last_wb_dst,
    output logic [DATA_W-1:0] last_wb_data,
    output logic [31:0]       retire_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              last_wb_valid_q, last_wb_valid_d;
    logic [ADDR_W-1:0] last_wb_dst_q,   last_wb_dst_d;
    logic [DATA_W-1:0] last_wb_data_q,  last_wb_data_d;
    logic [31:0]       retire_count_q,  retire_count_d;

    logic commit;

    assign wb_data_out = mem_to_reg_in ? read_data_in : alu_result_in;

    // Writes to r0 and writes presented during reset never reach state or the bypass path.
    assign commit = reg_write_in & ~rst & (wb_dst_in != '0);

    // A read sees the value retiring this cycle so ID never picks up a stale operand.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (commit && (wb_dst_in == addr)) begin
            return wb_data_out;
        end else begin
            return regs_q[addr];
        end
    endfunction

    always_comb begin
        rs_data = read_port(rs_addr);
        rt_data = read_port(rt_addr);
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (commit) begin
            regs_d[wb_dst_in] = wb_data_out;
        end
    end

    always_comb begin
        last_wb_valid_d = commit;
        last_wb_dst_d   = last_wb_dst_q;
        last_wb_data_d  = last_wb_data_q;
        retire_count_d  = retire_count_q;
        if (rst) begin
            last_wb_dst_d  = '0;
            last_wb_data_d = '0;
            retire_count_d = '0;
        end else if (commit) begin
            last_wb_dst_d  = wb_dst_in;
            last_wb_data_d = wb_data_out;
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    // NOTE: the whole array is cleared on reset because software relies on registers reading zero after boot;
    // that is why the clear lives in regs_d rather than being left to an uninitialised RAM.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        last_wb_valid_q <= last_wb_valid_d;
        last_wb_dst_q   <= last_wb_dst_d;
        last_wb_data_q  <= last_wb_data_d;
        retire_count_q  <= retire_count_d;
    end

    assign last_wb_valid = last_wb_valid_q;
    assign last_wb_dst   = last_wb_dst_q;
    assign last_wb_data  = last_wb_data_q;
    assign retire_count  = retire_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, bypass, r0 handling, mid-run reset, counter wrap.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [31:0] read_data_in;
    logic [31:0] alu_result_in;
    logic [4:0]  wb_dst_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data_out;
    logic        last_wb_valid;
    logic [4:0]  last_wb_dst;
    logic [31:0] last_wb_data;
    logic [31:0] retire_count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .reg_write_in  (reg_write_in),
        .mem_to_reg_in (mem_to_reg_in),
        .read_data_in  (read_data_in),
        .alu_result_in (alu_result_in),
        .wb_dst_in     (wb_dst_in),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_data_out   (wb_data_out),
        .last_wb_valid (last_wb_valid),
        .last_wb_dst   (last_wb_dst),
        .last_wb_data  (last_wb_data),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] dst);
        reg_write_in  = we;
        mem_to_reg_in = m2r;
        read_data_in  = rd;
        alu_result_in = alu;
        wb_dst_in     = dst;
    endtask

    // Advance across one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            n_checks++;
            if (rs_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rs[%0d]: got %h expected %h", i, rs_data, 32'h0);
            end
            n_checks++;
            if (rt_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rt[%0d]: got %h expected %h", 31 - i, rt_data, 32'h0);
            end
        end
        n_checks++;
        if (retire_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_retire_count: got %h expected %h", retire_count, 32'h0);
        end
        n_checks++;
        if (last_wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_last_valid: got %b expected %b", last_wb_valid, 1'b0);
        end
        n_checks++;
        if (last_wb_dst !== 5'd0 || last_wb_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_last_record: got %0d/%h expected 0/%h", last_wb_dst, last_wb_data, 32'h0);
        end
    endtask

    task automatic test_alu_bypass();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'hCAFE_0000, 32'h0000_1234, 5'd5);
        rs_addr = 5'd5;
        rt_addr = 5'd6;
        #1;
        n_checks++;
        if (rs_data !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL alu_bypass_rs: got %h expected %h", rs_data, 32'h0000_1234);
        end
        n_checks++;
        if (rt_data !== 32'h0) begin
            n_fail++;
            $display("FAIL alu_bypass_rt_other: got %h expected %h", rt_data, 32'h0);
        end
        n_checks++;
        if (wb_data_out !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL alu_wb_data: got %h expected %h", wb_data_out, 32'h0000_1234);
        end
        tick();
        reg_write_in = 1'b0;
        #1;
        n_checks++;
        if (rs_data !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL alu_array_rs: got %h expected %h", rs_data, 32'h0000_1234);
        end
        n_checks++;
        if (last_wb_valid !== 1'b1 || last_wb_dst !== 5'd5 || last_wb_data !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL alu_last_record: got %b/%0d/%h expected 1/5/%h",
                     last_wb_valid, last_wb_dst, last_wb_data, 32'h0000_1234);
        end
        n_checks++;
        if (retire_count !== 32'd1) begin
            n_fail++;
            $display("FAIL alu_retire_count: got %0d expected %0d", retire_count, 1);
        end
    endtask

    task automatic test_mem_dual_read();
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31);
        rs_addr = 5'd31;
        rt_addr = 5'd31;
        #1;
        n_checks++;
        if (wb_data_out !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL mem_wb_data: got %h expected %h", wb_data_out, 32'hDEAD_BEEF);
        end
        n_checks++;
        if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL mem_dual_bypass: got %h/%h expected %h", rs_data, rt_data, 32'hDEAD_BEEF);
        end
        tick();
        reg_write_in = 1'b0;
        #1;
        n_checks++;
        if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL mem_array_r31: got %h/%h expected %h", rs_data, rt_data, 32'hDEAD_BEEF);
        end
        n_checks++;
        if (retire_count !== 32'd2) begin
            n_fail++;
            $display("FAIL mem_retire_count: got %0d expected %0d", retire_count, 2);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
        rs_addr = 5'd0;
        rt_addr = 5'd5;
        #1;
        n_checks++;
        if (rs_data !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_read_during: got %h expected %h", rs_data, 32'h0);
        end
        n_checks++;
        if (rt_data !== 32'h0000_1234 || wb_data_out !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL r0_side_ports: got rt %h wb %h expected %h %h",
                     rt_data, wb_data_out, 32'h0000_1234, 32'hFFFF_FFFF);
        end
        tick();
        reg_write_in = 1'b0;
        #1;
        n_checks++;
        if (rs_data !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_read_after: got %h expected %h", rs_data, 32'h0);
        end
        n_checks++;
        if (retire_count !== 32'd2) begin
            n_fail++;
            $display("FAIL r0_retire_count: got %0d expected %0d", retire_count, 2);
        end
        n_checks++;
        if (last_wb_valid !== 1'b0 || last_wb_dst !== 5'd31 || last_wb_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL r0_last_record: got %b/%0d/%h expected 0/31/%h",
                     last_wb_valid, last_wb_dst, last_wb_data, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd1);
        rs_addr = 5'd1;
        rt_addr = 5'd2;
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h0000_0022, 32'h0000_0099, 5'd2);
        #1;
        n_checks++;
        if (rs_data !== 32'h0000_0011 || rt_data !== 32'h0000_0022) begin
            n_fail++;
            $display("FAIL b2b_reads: got %h/%h expected %h/%h", rs_data, rt_data, 32'h11, 32'h22);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_5555, 5'd5);
        rs_addr = 5'd5;
        rt_addr = 5'd1;
        #1;
        n_checks++;
        if (rs_data !== 32'h0000_5555 || rt_data !== 32'h0000_0011) begin
            n_fail++;
            $display("FAIL b2b_overwrite_bypass: got %h/%h expected %h/%h", rs_data, rt_data, 32'h5555, 32'h11);
        end
        tick();
        reg_write_in = 1'b0;
        rt_addr = 5'd2;
        #1;
        n_checks++;
        if (rs_data !== 32'h0000_5555 || rt_data !== 32'h0000_0022) begin
            n_fail++;
            $display("FAIL b2b_array: got %h/%h expected %h/%h", rs_data, rt_data, 32'h5555, 32'h22);
        end
        n_checks++;
        if (retire_count !== 32'd5 || last_wb_dst !== 5'd5 || last_wb_data !== 32'h0000_5555) begin
            n_fail++;
            $display("FAIL b2b_record: got %0d/%0d/%h expected 5/5/%h",
                     retire_count, last_wb_dst, last_wb_data, 32'h5555);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_00AA, 5'd7);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_00BB, 5'd8);
        rst = 1'b1;
        rs_addr = 5'd7;
        rt_addr = 5'd8;
        #1;
        n_checks++;
        if (rs_data !== 32'h0000_00AA || rt_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_no_bypass: got %h/%h expected %h/%h", rs_data, rt_data, 32'hAA, 32'h0);
        end
        tick();
        rst = 1'b0;
        reg_write_in = 1'b0;
        #1;
        n_checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_regs_cleared: got %h/%h expected %h", rs_data, rt_data, 32'h0);
        end
        n_checks++;
        if (retire_count !== 32'd0 || last_wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_counters: got %0d/%b expected 0/0", retire_count, last_wb_valid);
        end
        rs_addr = 5'd31;
        rt_addr = 5'd5;
        #1;
        n_checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0 || last_wb_dst !== 5'd0 || last_wb_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_other_state: got %h/%h/%0d/%h expected all zero",
                     rs_data, rt_data, last_wb_dst, last_wb_data);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0033, 5'd3);
        tick();
        reg_write_in = 1'b0;
        #1;
        n_checks++;
        if (retire_count !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_to_zero: got %h expected %h", retire_count, 32'h0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0044, 5'd4);
        tick();
        reg_write_in = 1'b0;
        #1;
        n_checks++;
        if (retire_count !== 32'd1 || last_wb_dst !== 5'd4 || last_wb_data !== 32'h0000_0044) begin
            n_fail++;
            $display("FAIL wrap_continue: got %0d/%0d/%h expected 1/4/%h",
                     retire_count, last_wb_dst, last_wb_data, 32'h44);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        test_reset();
        test_alu_bypass();
        test_mem_dual_read();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
